// File: rtl/mem_port_arbiter.sv
// Two-requester (instruction fetch / data) arbiter onto a single shared memory port.
// Round-robin on ties, fixed MEM_LAT access cycles, one-cycle response with ack.
module mem_port_arbiter #(
  parameter int AW      = 13,
  parameter int DW      = 32,
  parameter int MEM_LAT = 2
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic          if_ack,
  output logic [DW-1:0] if_rdata,
  input  logic          dm_req,
  input  logic          dm_we,
  input  logic [AW-1:0] dm_addr,
  input  logic [DW-1:0] dm_wdata,
  output logic          dm_ack,
  output logic [DW-1:0] dm_rdata,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          busy
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  localparam logic [3:0] LAST_CNT = 4'(MEM_LAT - 1);

  state_t          state;
  state_t          state_nxt;
  logic [3:0]      cnt;
  logic            last_dm;
  logic            lat_we;
  logic [AW-1:0]   lat_addr;
  logic [DW-1:0]   lat_wdata;
  logic            pick_dm;

  // last_dm doubles as the current grant while a transaction is in flight.
  assign pick_dm = dm_req & (~if_req | ~last_dm);

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (if_req || dm_req) state_nxt = ACCESS;
      ACCESS:  if (cnt == LAST_CNT)  state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt       <= '0;
      last_dm   <= 1'b1;
      lat_we    <= 1'b0;
      lat_addr  <= '0;
      lat_wdata <= '0;
      if_rdata  <= '0;
      dm_rdata  <= '0;
    end else begin
      case (state)
        IDLE: begin
          cnt <= '0;
          if (if_req || dm_req) begin
            last_dm   <= pick_dm;
            lat_addr  <= pick_dm ? dm_addr : if_addr;
            lat_we    <= pick_dm & dm_we;
            lat_wdata <= pick_dm ? dm_wdata : '0;
          end
        end
        ACCESS: begin
          cnt <= cnt + 4'd1;
          if (cnt == LAST_CNT && !lat_we) begin
            if (last_dm) dm_rdata <= mem_rdata;
            else         if_rdata <= mem_rdata;
          end
        end
        default: cnt <= '0;
      endcase
    end
  end

  always_comb begin
    mem_en    = (state == ACCESS);
    mem_we    = (state == ACCESS) & lat_we;
    mem_addr  = lat_addr;
    mem_wdata = lat_wdata;
    if_ack    = (state == RESP) & ~last_dm;
    dm_ack    = (state == RESP) &  last_dm;
    busy      = (state != IDLE);
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized bench for mem_port_arbiter: a transaction-level model with an ideal
// shadow memory predicts every output each cycle.
module tb_mem_port_arbiter;

  localparam int AW  = 13;
  localparam int DW  = 32;
  localparam int LAT = 2;
  localparam int NCYC = 4000;

  logic          clk = 1'b0;
  logic          reset;
  logic          if_req;
  logic [AW-1:0] if_addr;
  logic          if_ack;
  logic [DW-1:0] if_rdata;
  logic          dm_req;
  logic          dm_we;
  logic [AW-1:0] dm_addr;
  logic [DW-1:0] dm_wdata;
  logic          dm_ack;
  logic [DW-1:0] dm_rdata;
  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic          busy;

  mem_port_arbiter #(.AW(AW), .DW(DW), .MEM_LAT(LAT)) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_ack(dm_ack), .dm_rdata(dm_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .busy(busy)
  );

  always #5 clk = ~clk;

  // Memory device attached to the shared port.
  logic [DW-1:0] mem [0:(1<<AW)-1];
  always @(posedge clk) if (mem_en && mem_we) mem[mem_addr] <= mem_wdata;
  assign mem_rdata = mem[mem_addr];

  // Reference model: t is the cycle index within a transaction (0 = idle).
  logic [DW-1:0] shadow [0:(1<<AW)-1];
  int            t;
  bit            m_last_dm;
  bit            m_dm;
  bit            m_we;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata;
  logic [DW-1:0] exp_if;
  logic [DW-1:0] exp_dm;
  bit            in_acc;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  initial begin
    for (int unsigned i = 0; i < (1 << AW); i++) begin
      mem[i]    = $urandom;
      shadow[i] = mem[i];
    end
    reset = 1'b1; if_req = 1'b1; dm_req = 1'b1; dm_we = 1'b0;
    if_addr = '0; dm_addr = '0; dm_wdata = '0;
    t = 0; m_last_dm = 1'b1; m_dm = 1'b0; m_we = 1'b0;
    m_addr = '0; m_wdata = '0; exp_if = '0; exp_dm = '0;

    for (int n = 0; n < NCYC; n++) begin
      @(negedge clk);
      in_acc = (t >= 1) && (t <= LAT);
      chk("busy",     busy,     t != 0);
      chk("mem_en",   mem_en,   in_acc);
      chk("mem_we",   mem_we,   in_acc && m_we);
      if (in_acc) chk("mem_addr", mem_addr, m_addr);
      if (in_acc && m_we) chk("mem_wdata", mem_wdata, m_wdata);
      chk("if_ack",   if_ack,   (t == LAT + 1) && !m_dm);
      chk("dm_ack",   dm_ack,   (t == LAT + 1) &&  m_dm);
      chk("if_rdata", if_rdata, exp_if);
      chk("dm_rdata", dm_rdata, exp_dm);

      if (n < 2) begin
        reset = 1'b1; if_req = 1'b1; dm_req = 1'b1;
      end else begin
        reset = ($urandom_range(0, 59) == 0);
        if (!if_req || if_ack) begin
          if_req  = ($urandom_range(0, 3) != 0);
          if_addr = AW'($urandom_range(0, 31));
        end
        if (!dm_req || dm_ack) begin
          dm_req   = ($urandom_range(0, 3) != 0);
          dm_we    = $urandom_range(0, 1);
          dm_addr  = AW'($urandom_range(0, 31));
          dm_wdata = $urandom;
        end
      end

      // Advance the model across the coming rising edge.
      if (reset) begin
        if (t >= 1 && t <= LAT && m_we) shadow[m_addr] = m_wdata;
        t = 0; m_last_dm = 1'b1; exp_if = '0; exp_dm = '0;
      end else if (t == 0) begin
        if (if_req || dm_req) begin
          m_dm      = (if_req && dm_req) ? !m_last_dm : dm_req;
          m_last_dm = m_dm;
          m_addr    = m_dm ? dm_addr : if_addr;
          m_we      = m_dm && dm_we;
          m_wdata   = dm_wdata;
          t = 1;
        end
      end else if (t < LAT) begin
        t++;
      end else if (t == LAT) begin
        if (m_we)      shadow[m_addr] = m_wdata;
        else if (m_dm) exp_dm = shadow[m_addr];
        else           exp_if = shadow[m_addr];
        t = LAT + 1;
      end else begin
        t = 0;
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 The block SHALL have parameter AW, default 13, meaning memory address width.
REQ-002 The block SHALL have parameter DW, default 32, meaning data width.
REQ-003 The block SHALL have parameter MEM_LAT, default 2, legal 1..15, meaning memory access cycles per transaction.
REQ-004 The block SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-005 The block SHALL have port reset, input, 1, synchronous active-high reset.
REQ-006 The block SHALL have port if_req, input, 1, fetch request, held until if_ack.
REQ-007 The block SHALL have port if_addr, input, AW, fetch address, stable while if_req is high.
REQ-008 The block SHALL have port if_ack, output, 1, one-cycle fetch completion pulse.
REQ-009 The block SHALL have port if_rdata, output, DW, fetched word, valid with if_ack and held afterwards.
REQ-010 The block SHALL have port dm_req, input, 1, data request, held until dm_ack.
REQ-011 The block SHALL have port dm_we, input, 1, 1 = write, 0 = read.
REQ-012 The block SHALL have port dm_addr, input, AW, data address.
REQ-013 The block SHALL have port dm_wdata, input, DW, write data.
REQ-014 The block SHALL have port dm_ack, output, 1, one-cycle data completion pulse.
REQ-015 The block SHALL have port dm_rdata, output, DW, read word, valid with dm_ack.
REQ-016 The block SHALL have ports mem_en, mem_we, mem_addr[AW], mem_wdata[DW] as outputs and mem_rdata[DW] as input: the single shared memory port.
REQ-017 The block SHALL have port busy, output, 1, high whenever the state is not IDLE.

Function
REQ-018 The FSM SHALL have states IDLE, ACCESS and RESP.
REQ-019 In IDLE, the FSM SHALL sample if_req and dm_req at the clock edge and go to ACCESS if either is high; otherwise it SHALL stay in IDLE.
REQ-020 On entering ACCESS, the block SHALL latch the winner's address, write enable and write data; fetch is always a read.
REQ-021 A single pending request SHALL be granted.
REQ-022 When both requests are pending, the block SHALL grant the requester not granted last (round robin).
REQ-023 The last-grant register SHALL update on every grant.
REQ-024 ACCESS SHALL last exactly MEM_LAT cycles, counted by a 4-bit counter.
REQ-025 During ACCESS, mem_en SHALL be 1 and mem_addr, mem_we and mem_wdata SHALL come from the latched values; mem_we SHALL be high in every ACCESS cycle of a write.
REQ-026 In all other states, mem_en and mem_we SHALL be 0.
REQ-027 For a read, mem_rdata SHALL be captured at the edge ending the last ACCESS cycle, into if_rdata or dm_rdata per the grant.
REQ-028 RESP SHALL last one cycle, with the granted ack high, and SHALL return to IDLE.
REQ-029 Latency: request sampled at edge E0 SHALL produce its ack in cycle MEM_LAT+1 after E0; throughput SHALL be one transaction per MEM_LAT+2 cycles.
REQ-030 if_ack and dm_ack SHALL never be high together, and each SHALL never be high for two consecutive cycles.
REQ-031 A req still high in the IDLE cycle after an ack SHALL be treated as a new request.
REQ-032 A write SHALL leave dm_rdata unchanged.
REQ-033 Request changes during ACCESS or RESP SHALL be ignored.

Reset
REQ-034 While reset is high at a clock edge, the block SHALL go to IDLE, clear the counter and set last-grant to DM, so that IF wins the first tie.
REQ-035 Reset SHALL clear if_rdata and dm_rdata to 0, and if_ack, dm_ack, mem_en, mem_we and busy to 0.
REQ-036 Reset during ACCESS or RESP SHALL abort the transaction with no ack issued; mem_en SHALL be 0 from the cycle after the reset edge.
REQ-037 Requests held through reset SHALL first be sampled in the first IDLE cycle after reset deasserts.

Verification (MEM_LAT=2, cycle 0 = IDLE sampling cycle)
REQ-038 Reset held 2 cycles with both reqs high -> no acks, mem_en=0, rdata=0; after release, the first grant SHALL go to IF.
REQ-039 IF read of 0x004 with mem_rdata=0x20100005 in cycle 2 -> mem_en=1 and mem_we=0 in cycles 1-2, mem_addr=0x004, if_ack in cycle 3, if_rdata=0x20100005.
REQ-040 DM write of 0xDEADBEEF to 0x0100 -> mem_we=1 with mem_addr=0x0100 in cycles 1-2, dm_ack in cycle 3, dm_rdata unchanged.
REQ-041 Both reqs held continuously -> grants alternate IF, DM, IF, DM; one ack every 4 cycles; never both acks together.
REQ-042 Reset asserted in cycle 1 of a DM read -> no dm_ack, mem_en=0 in cycle 2, busy=0; with both reqs pending afterwards, the next grant SHALL go to IF.
REQ-043 IF holds if_req with a new address after if_ack and dm_req=0 -> IF SHALL be re-granted in the next IDLE cycle and acked 4 cycles after the first ack.
